// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg: control codes, sequencer states and word geometry shared by the
// MEM-stage sequencer and the data memory.
package cpu_ctrl_pkg;
    localparam logic [3:0] OP_OR  = 4'b0000;
    localparam logic [3:0] OP_AND = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0011;
    localparam logic [3:0] OP_XOR = 4'b0100;
    localparam logic [3:0] OP_SLT = 4'b0101;
    localparam logic [3:0] OP_LW  = 4'b0110;
    localparam logic [3:0] OP_SW  = 4'b0111;
    localparam logic [3:0] OP_BEQ = 4'b1000;

    localparam int BYTES_DEFAULT = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_XFER,
        ST_RESP
    } state_e;
endpackage

// File: rtl/mem_word_sequencer.sv
// mem_word_sequencer: splits one lw/sw into BYTES little-endian single-byte
// accesses on a byte-wide data-memory port, then pulses a completion response.
module mem_word_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter int BYTES = BYTES_DEFAULT,
    parameter int AW    = 32
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          req_valid_i,
    output logic          req_ready_o,
    input  logic [3:0]    req_ctrl_i,
    input  logic [AW-1:0] req_addr_i,
    input  logic [31:0]   req_wdata_i,
    output logic [AW-1:0] mem_addr_o,
    output logic          mem_re_o,
    output logic          mem_we_o,
    output logic [7:0]    mem_wdata_o,
    input  logic [7:0]    mem_rdata_i,
    output logic          rsp_valid_o,
    output logic [31:0]   rsp_rdata_o,
    output logic          busy_o
);
    localparam int BW = $clog2(BYTES);
    localparam int W  = 8 * BYTES;
    localparam logic [BW-1:0] LAST = BW'(BYTES - 1);

    state_e        state_q, state_d;
    logic [BW-1:0] beat_q;
    logic [AW-1:0] addr_q;
    logic [31:0]   wdata_q;
    logic          load_q;
    logic [W-1:0]  lw_q, lw_d;
    logic          is_mem, accept, xfer;

    assign is_mem      = (req_ctrl_i == OP_LW) || (req_ctrl_i == OP_SW);
    assign accept      = (state_q == ST_IDLE) && req_valid_i && is_mem;
    assign xfer        = state_q == ST_XFER;
    assign req_ready_o = state_q == ST_IDLE;
    assign busy_o      = !req_ready_o;
    assign rsp_valid_o = state_q == ST_RESP;
    assign mem_re_o    = xfer && load_q;
    assign mem_we_o    = xfer && !load_q;
    assign mem_addr_o  = xfer ? addr_q + AW'(beat_q) : '0;
    assign mem_wdata_o = mem_we_o ? wdata_q[8*beat_q +: 8] : '0;

    // Load word with the current beat's byte merged in, so the final beat can
    // land in rsp_rdata_o on the same edge that enters RESP.
    always_comb begin
        lw_d = lw_q;
        lw_d[8*beat_q +: 8] = mem_rdata_i;
        state_d = state_q;
        case (state_q)
            ST_IDLE: state_d = accept ? ST_XFER : ST_IDLE;
            ST_XFER: state_d = (beat_q == LAST) ? ST_RESP : ST_XFER;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            beat_q      <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            load_q      <= 1'b0;
            lw_q        <= '0;
            rsp_rdata_o <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                addr_q  <= req_addr_i;
                wdata_q <= req_wdata_i;
                load_q  <= req_ctrl_i == OP_LW;
                beat_q  <= '0;
            end else if (xfer) begin
                beat_q <= beat_q + 1'b1;
            end
            if (mem_re_o) lw_q <= lw_d;
            if (mem_re_o && beat_q == LAST) rsp_rdata_o <= 32'(lw_d);
        end
    end
endmodule

// File: tb/tb_mem_word_sequencer.sv
// tb_mem_word_sequencer: directed vector table plus hand-written reset and
// back-to-back sequences against a byte-wide memory model.
module tb_mem_word_sequencer;
    import cpu_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        req_valid_i;
    logic        req_ready_o;
    logic [3:0]  req_ctrl_i;
    logic [31:0] req_addr_i;
    logic [31:0] req_wdata_i;
    logic [31:0] mem_addr_o;
    logic        mem_re_o;
    logic        mem_we_o;
    logic [7:0]  mem_wdata_o;
    logic [7:0]  mem_rdata_i;
    logic        rsp_valid_o;
    logic [31:0] rsp_rdata_o;
    logic        busy_o;

    mem_word_sequencer dut (
        .clk_i(clk), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_ctrl_i(req_ctrl_i), .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
        .mem_addr_o(mem_addr_o), .mem_re_o(mem_re_o), .mem_we_o(mem_we_o),
        .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i),
        .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [0:255];
    logic       pre_we = 1'b0;
    logic [7:0] pre_a = '0, pre_d = '0;

    always @(posedge clk) begin
        if (pre_we) mem[pre_a] <= pre_d;
        else if (mem_we_o) mem[mem_addr_o[7:0]] <= mem_wdata_o;
    end
    assign mem_rdata_i = mem[mem_addr_o[7:0]];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic poke(input logic [7:0] a, input logic [7:0] d);
        pre_we = 1'b1;
        pre_a  = a;
        pre_d  = d;
        @(negedge clk);
        pre_we = 1'b0;
    endtask

    typedef struct {
        logic [3:0]  ctrl;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[5];

    task automatic run_op(input vec_t v);
        bit          m  = (v.ctrl == OP_LW) || (v.ctrl == OP_SW);
        bit          ld = v.ctrl == OP_LW;
        logic [31:0] a;
        req_valid_i = 1'b1;
        req_ctrl_i  = v.ctrl;
        req_addr_i  = v.addr;
        req_wdata_i = v.wdata;
        chk("ready_before", 32'(req_ready_o), 32'd1);
        @(negedge clk);
        req_valid_i = 1'b0;
        req_addr_i  = ~v.addr;
        req_wdata_i = ~v.wdata;
        if (m) begin
            for (int b = 0; b < 4; b++) begin
                chk("beat_busy", 32'(busy_o), 32'd1);
                chk("beat_ready", 32'(req_ready_o), 32'd0);
                chk("beat_re", 32'(mem_re_o), 32'(ld));
                chk("beat_we", 32'(mem_we_o), 32'(!ld));
                chk("beat_addr", mem_addr_o, v.addr + 32'(b));
                chk("beat_wdata", 32'(mem_wdata_o), ld ? 32'd0 : 32'(v.wdata[8*b +: 8]));
                chk("beat_no_rsp", 32'(rsp_valid_o), 32'd0);
                @(negedge clk);
            end
            chk("rsp_valid", 32'(rsp_valid_o), 32'd1);
            chk("rsp_rdata", rsp_rdata_o, v.exp);
            chk("rsp_strobes", {30'd0, mem_re_o, mem_we_o}, 32'd0);
            chk("rsp_busy", 32'(busy_o), 32'd1);
            @(negedge clk);
            chk("post_valid", 32'(rsp_valid_o), 32'd0);
            chk("post_ready", 32'(req_ready_o), 32'd1);
            chk("post_rdata_hold", rsp_rdata_o, v.exp);
            if (!ld) begin
                for (int b = 0; b < 4; b++) begin
                    a = v.addr + 32'(b);
                    chk("mem_written", 32'(mem[a[7:0]]), 32'(v.wdata[8*b +: 8]));
                end
            end
        end else begin
            for (int c = 0; c < 3; c++) begin
                chk("nop_ready", 32'(req_ready_o), 32'd1);
                chk("nop_busy", 32'(busy_o), 32'd0);
                chk("nop_strobes", {30'd0, mem_re_o, mem_we_o}, 32'd0);
                chk("nop_addr", mem_addr_o, 32'd0);
                chk("nop_rsp", 32'(rsp_valid_o), 32'd0);
                chk("nop_rdata", rsp_rdata_o, v.exp);
                @(negedge clk);
            end
        end
    endtask

    initial begin
        rst_i       = 1'b1;
        req_valid_i = 1'b0;
        req_ctrl_i  = '0;
        req_addr_i  = '0;
        req_wdata_i = '0;
        @(negedge clk);
        poke(8'h10, 8'h44); poke(8'h11, 8'h33); poke(8'h12, 8'h22); poke(8'h13, 8'h11);
        poke(8'hFE, 8'hA1); poke(8'hFF, 8'hB2); poke(8'h00, 8'hC3); poke(8'h01, 8'hD4);
        poke(8'h08, 8'h00); poke(8'h09, 8'h00); poke(8'h0A, 8'h00); poke(8'h0B, 8'h00);

        chk("rst_ready", 32'(req_ready_o), 32'd1);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_strobes", {30'd0, mem_re_o, mem_we_o}, 32'd0);
        chk("rst_addr", mem_addr_o, 32'd0);
        chk("rst_wdata", 32'(mem_wdata_o), 32'd0);
        chk("rst_rsp", 32'(rsp_valid_o), 32'd0);
        chk("rst_rdata", rsp_rdata_o, 32'd0);
        rst_i = 1'b0;
        @(negedge clk);

        vecs[0] = '{OP_LW,  32'h0000_0010, 32'h0,          32'h1122_3344};
        vecs[1] = '{OP_SW,  32'h0000_0004, 32'hDEAD_BEEF, 32'h1122_3344};
        vecs[2] = '{OP_LW,  32'h0000_0004, 32'h0,          32'hDEAD_BEEF};
        vecs[3] = '{OP_ADD, 32'h0000_0010, 32'h1234_5678, 32'hDEAD_BEEF};
        vecs[4] = '{OP_LW,  32'hFFFF_FFFE, 32'h0,          32'hD4C3_B2A1};
        for (int i = 0; i < 5; i++) run_op(vecs[i]);

        req_valid_i = 1'b1;
        req_ctrl_i  = OP_SW;
        req_addr_i  = 32'h08;
        req_wdata_i = 32'hAABB_CCDD;
        @(negedge clk);
        req_valid_i = 1'b0;
        chk("rst_mid_b0", 32'(mem_wdata_o), 32'hDD);
        @(negedge clk);
        chk("rst_mid_b1", 32'(mem_wdata_o), 32'hCC);
        rst_i = 1'b1;
        @(negedge clk);
        rst_i = 1'b0;
        chk("rst_mid_ready", 32'(req_ready_o), 32'd1);
        chk("rst_mid_busy", 32'(busy_o), 32'd0);
        chk("rst_mid_strobes", {30'd0, mem_re_o, mem_we_o}, 32'd0);
        chk("rst_mid_rdata", rsp_rdata_o, 32'd0);
        chk("rst_mid_m8", 32'(mem[8'h08]), 32'hDD);
        chk("rst_mid_m9", 32'(mem[8'h09]), 32'hCC);
        chk("rst_mid_m10", 32'(mem[8'h0A]), 32'h00);
        chk("rst_mid_m11", 32'(mem[8'h0B]), 32'h00);
        for (int c = 0; c < 4; c++) begin
            chk("rst_mid_no_rsp", 32'(rsp_valid_o), 32'd0);
            chk("rst_mid_no_we", 32'(mem_we_o), 32'd0);
            @(negedge clk);
        end

        req_valid_i = 1'b1;
        req_ctrl_i  = OP_LW;
        req_addr_i  = 32'h10;
        for (int n = 1; n <= 14; n++) begin
            @(negedge clk);
            if (n == 2) req_addr_i = 32'h04;
            chk("b2b_rsp_timing", 32'(rsp_valid_o), 32'((n == 5) || (n == 11)));
            chk("b2b_ready", 32'(req_ready_o), 32'((n == 6) || (n >= 12)));
            if (n == 1) chk("b2b_addr1", mem_addr_o, 32'h10);
            if (n == 7) chk("b2b_addr2", mem_addr_o, 32'h04);
            if (n == 5) chk("b2b_rdata1", rsp_rdata_o, 32'h1122_3344);
            if (n == 11) chk("b2b_rdata2", rsp_rdata_o, 32'hDEAD_BEEF);
            if (n == 7) req_valid_i = 1'b0;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
